// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan driver: dark codes,
// hex-to-segment table (active-low {g,f,e,d,c,b,a}) and slot state encoding.
package seg_pkg;

   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [3:0] DIG_OFF = 4'hF;

   // Entry n is the segment pattern for hex digit n; listed from F down to 0.
   localparam logic [15:0][6:0] HEX_SEG = {
      7'b0001110,   // F
      7'b0000110,   // E
      7'b0100001,   // d
      7'b1000110,   // C
      7'b0000011,   // b
      7'b0001000,   // A
      7'b0010000,   // 9
      7'b0000000,   // 8
      7'b1111000,   // 7
      7'b0000010,   // 6
      7'b0010010,   // 5
      7'b0011001,   // 4
      7'b0110000,   // 3
      7'b0100100,   // 2
      7'b1111001,   // 1
      7'b1000000    // 0
   };

   typedef enum logic {
      S_BLANK = 1'b0,
      S_SHOW  = 1'b1
   } state_t;

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational hex nibble to active-low segment pattern lookup.
module hex7seg_decode
   import seg_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   // Straight table lookup; all 16 codes are defined.
   always_comb begin
      seg = HEX_SEG[nib];
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed common-anode 7-segment driver.
// Each digit slot starts with a dead-time blank, then shows one nibble of a
// snapshot that is refreshed only when the scan wraps from digit 3 to digit 0,
// so a frame never mixes two different input words.
// All outputs are registered from the next-state values, so they always match
// the state/idx/snapshot registers in the same cycle.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int DWELL_CYC    = 50000,
   parameter int BLANK_CYC    = 500,
   parameter int BLINK_FRAMES = 125
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] disp_num,
   input  logic        disp_en,
   input  logic        lz_suppress,
   input  logic [3:0]  blink_mask,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  dig_sel,
   output logic        frame_tick
);

   localparam int CW = $clog2(DWELL_CYC);
   localparam int FW = $clog2(BLINK_FRAMES + 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYC - 1);
   localparam logic [FW-1:0] BLINK_LAST = FW'(BLINK_FRAMES - 1);

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [1:0]    idx, idx_nx;
   logic [15:0]   snapshot, snapshot_nx;
   logic [FW-1:0] frame_cnt, frame_cnt_nx;
   logic          blink_phase, blink_phase_nx;
   logic          wrap;
   logic [3:0]    nib_nx;
   logic [6:0]    seg_dec;
   logic          lead_zero_nx;
   logic          dark_nx;

   // Slot timing, digit advance, frame snapshot and blink phase.
   always_comb begin
      state_nx       = state;
      cnt_nx         = cnt + CW'(1);
      idx_nx         = idx;
      snapshot_nx    = snapshot;
      frame_cnt_nx   = frame_cnt;
      blink_phase_nx = blink_phase;
      wrap           = 1'b0;
      if (state == S_BLANK) begin
         if (cnt == BLANK_LAST) begin
            state_nx = S_SHOW;
         end
      end else if (cnt == DWELL_LAST) begin
         cnt_nx   = '0;
         state_nx = S_BLANK;
         idx_nx   = idx + 2'd1;
         if (idx == 2'd3) begin
            wrap        = 1'b1;
            snapshot_nx = disp_num;
            if (frame_cnt == BLINK_LAST) begin
               frame_cnt_nx   = '0;
               blink_phase_nx = ~blink_phase;
            end else begin
               frame_cnt_nx = frame_cnt + FW'(1);
            end
         end
      end
   end

   // Digit selection and darkening for the upcoming cycle.
   always_comb begin
      nib_nx       = snapshot_nx[{idx_nx, 2'b00} +: 4];
      lead_zero_nx = (snapshot_nx >> {idx_nx, 2'b00}) == 16'h0000;
      dark_nx      = !disp_en
                   || (lz_suppress && (idx_nx != 2'd0) && lead_zero_nx)
                   || (blink_phase_nx && blink_mask[idx_nx]);
   end

   hex7seg_decode u_decode (
      .nib (nib_nx),
      .seg (seg_dec)
   );

   // State registers plus registered outputs derived from next-state values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_BLANK;
         cnt         <= '0;
         idx         <= 2'd0;
         snapshot    <= 16'h0000;
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
         frame_tick  <= 1'b0;
         seg         <= SEG_OFF;
         dig_sel     <= DIG_OFF;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         idx         <= idx_nx;
         snapshot    <= snapshot_nx;
         frame_cnt   <= frame_cnt_nx;
         blink_phase <= blink_phase_nx;
         frame_tick  <= wrap;
         if (state_nx == S_SHOW && !dark_nx) begin
            seg     <= seg_dec;
            dig_sel <= ~(4'b0001 << idx_nx);
         end else begin
            seg     <= SEG_OFF;
            dig_sel <= DIG_OFF;
         end
      end
   end

   // The decimal point is never used on this board.
   assign dp = 1'b1;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver with short slot timing.
// The reference model derives everything from the cycle count since reset:
// slot = k / DWELL, position in slot = k % DWELL, frame = k / (4*DWELL).
module tb_seg_scan_driver;

   localparam int DWELL  = 8;
   localparam int BLANK  = 2;
   localparam int BLINKF = 2;
   localparam int FRAME  = 4 * DWELL;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] disp_num = 16'h0000;
   logic        disp_en = 1'b1;
   logic        lz_suppress = 1'b0;
   logic [3:0]  blink_mask = 4'h0;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  dig_sel;
   logic        frame_tick;

   always #5 clk = ~clk;

   seg_scan_driver #(
      .DWELL_CYC    (DWELL),
      .BLANK_CYC    (BLANK),
      .BLINK_FRAMES (BLINKF)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .disp_num    (disp_num),
      .disp_en     (disp_en),
      .lz_suppress (lz_suppress),
      .blink_mask  (blink_mask),
      .seg         (seg),
      .dp          (dp),
      .dig_sel     (dig_sel),
      .frame_tick  (frame_tick)
   );

   // ---------------- scoreboard state ----------------
   int          checks = 0;
   int          errors = 0;
   int          k = 0;            // cycles since reset release
   logic [15:0] m_snap = 16'h0000; // word the model expects on display this frame

   typedef struct {
      logic [15:0]     num;
      logic            lz;
      logic [3:0][6:0] exp_seg;   // index = digit number, 7F = dark
   } vec_t;

   vec_t vecs [6];

   function automatic vec_t mk(logic [15:0] num, logic lz, logic [6:0] d3, logic [6:0] d2,
                               logic [6:0] d1, logic [6:0] d0);
      vec_t v;
      v.num = num;
      v.lz  = lz;
      v.exp_seg = {d3, d2, d1, d0};
      return v;
   endfunction

   function automatic logic [6:0] ref_seg(logic [3:0] n);
      case (n)
         4'h0: return 7'b1000000;
         4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;
         4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;
         4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;
         4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;
         4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;
         4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;
         default: return 7'b0001110;
      endcase
   endfunction

   function automatic logic [3:0] one_cold(int d);
      case (d)
         0: return 4'hE;
         1: return 4'hD;
         2: return 4'hB;
         default: return 4'h7;
      endcase
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s k=%0d got %h expected %h", name, k, act, exp);
      end
   endtask

   // Reference model for the cycle k currently visible on the outputs.
   task automatic model_check();
      int   pos, d, frame;
      logic phase, dark;
      logic [6:0] es;
      logic [3:0] ed;
      pos   = k % DWELL;
      d     = (k / DWELL) % 4;
      frame = k / FRAME;
      phase = ((frame / BLINKF) % 2) == 1;
      dark  = (pos < BLANK) || !disp_en
           || (lz_suppress && d != 0 && (m_snap >> (4 * d)) == 16'h0000)
           || (phase && blink_mask[d]);
      es = dark ? 7'h7F : ref_seg(m_snap[4*d +: 4]);
      ed = dark ? 4'hF : one_cold(d);
      check("seg", 32'(seg), 32'(es));
      check("dig_sel", 32'(dig_sel), 32'(ed));
      check("frame_tick", 32'(frame_tick), 32'(k > 0 && pos == 0 && d == 0));
      check("dp", 32'(dp), 32'd1);
      check("one_cold", 32'($countones(~dig_sel) <= 1), 32'd1);
   endtask

   // ---------------- driver tasks ----------------
   // Advance one clock; the word sampled at a frame-ending edge becomes the next frame's snapshot.
   task automatic step();
      if ((k + 1) % FRAME == 0) m_snap = disp_num;
      @(negedge clk);
      k++;
      model_check();
   endtask

   task automatic run_to(int target);
      while (k < target) step();
   endtask

   task automatic do_reset();
      #1 rst_n = 1'b0;
      #1;
      check("rst_seg", 32'(seg), 32'h7F);
      check("rst_dig_sel", 32'(dig_sel), 32'hF);
      check("rst_frame_tick", 32'(frame_tick), 32'd0);
      @(negedge clk);
      rst_n  = 1'b1;
      k      = 0;
      m_snap = 16'h0000;
      model_check();
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int          lit, ticks, first_tick;
      logic [7:0]  blink_dark;
      logic [6:0]  exp_s;
      logic [3:0]  exp_d;
      int          d;

      vecs[0] = mk(16'h1234, 1'b0, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001);
      vecs[1] = mk(16'h0070, 1'b1, 7'h7F,      7'h7F,      7'b1111000, 7'b1000000);
      vecs[2] = mk(16'h0070, 1'b0, 7'b1000000, 7'b1000000, 7'b1111000, 7'b1000000);
      vecs[3] = mk(16'hABCD, 1'b0, 7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001);
      vecs[4] = mk(16'h0000, 1'b1, 7'h7F,      7'h7F,      7'h7F,      7'b1000000);
      vecs[5] = mk(16'h5E0F, 1'b1, 7'b0010010, 7'b0000110, 7'b1000000, 7'b0001110);

      // Table: frame 0 shows the reset snapshot, frame 1 shows the vector word.
      for (int v = 0; v < 6; v++) begin
         disp_en     = 1'b1;
         blink_mask  = 4'h0;
         lz_suppress = vecs[v].lz;
         disp_num    = vecs[v].num;
         do_reset();
         for (int c = 0; c < 2 * FRAME; c++) begin
            if ((c % DWELL) == BLANK) begin
               d = (c / DWELL) % 4;
               if (c < FRAME) exp_s = (vecs[v].lz && d != 0) ? 7'h7F : 7'b1000000;
               else           exp_s = vecs[v].exp_seg[d];
               exp_d = (exp_s == 7'h7F) ? 4'hF : one_cold(d);
               check("vec_seg", 32'(seg), 32'(exp_s));
               check("vec_dig_sel", 32'(dig_sel), 32'(exp_d));
            end
            step();
         end
      end

      // Input word changes in the middle of a frame.
      lz_suppress = 1'b0;
      disp_num = 16'h1234;
      do_reset();
      run_to(FRAME + 2 * DWELL);
      disp_num = 16'hABCD;
      run_to(FRAME + 2 * DWELL + BLANK);
      check("mid_d2_old", 32'(seg), 32'(7'b0100100));
      run_to(FRAME + 3 * DWELL + BLANK);
      check("mid_d3_old", 32'(seg), 32'(7'b1111001));
      run_to(2 * FRAME + BLANK);
      check("mid_d0_new", 32'(seg), 32'(7'b0100001));
      run_to(2 * FRAME + 3 * DWELL + BLANK);
      check("mid_d3_new", 32'(seg), 32'(7'b0001000));

      // Blink on digit 0, two frames per half-period.
      disp_num   = 16'h1234;
      blink_mask = 4'b0001;
      blink_dark = 8'b1100_1100;
      do_reset();
      for (int f = 0; f < 8; f++) begin
         run_to(f * FRAME + BLANK);
         check("blink_d0_dark", 32'(dig_sel == 4'hF), 32'(blink_dark[f]));
         run_to(f * FRAME + DWELL + BLANK);
         check("blink_d1", 32'(dig_sel), 32'hD);
      end

      // Display disabled: dark throughout, frame ticks continue.
      disp_en    = 1'b0;
      blink_mask = 4'h0;
      do_reset();
      lit = 0;
      ticks = 0;
      first_tick = -1;
      while (k <= 3 * FRAME) begin
         if (dig_sel != 4'hF || seg != 7'h7F) lit++;
         if (frame_tick) begin
            ticks++;
            if (first_tick < 0) first_tick = k;
         end
         step();
      end
      check("en0_lit_cycles", 32'(lit), 32'd0);
      check("en0_ticks", 32'(ticks), 32'd3);
      check("en0_first_tick", 32'(first_tick), 32'(FRAME));

      // Asynchronous reset while digit 2 is lit in a blink-off frame.
      disp_en    = 1'b1;
      blink_mask = 4'b0001;
      do_reset();
      run_to(2 * FRAME + 2 * DWELL + BLANK + 1);
      check("pre_rst_dig2", 32'(dig_sel), 32'hB);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_seg", 32'(seg), 32'h7F);
      check("async_rst_dig", 32'(dig_sel), 32'hF);
      @(posedge clk);
      #1;
      check("held_rst_dig", 32'(dig_sel), 32'hF);
      @(negedge clk);
      rst_n  = 1'b1;
      k      = 0;
      m_snap = 16'h0000;
      model_check();
      run_to(BLANK);
      check("post_rst_d0_lit", 32'(dig_sel), 32'hE);
      check("post_rst_d0_zero", 32'(seg), 32'(7'b1000000));

      // Randomized run against the reference model.
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(3, 0) == 0) begin
            disp_num = 16'($urandom);
            for (int n = 0; n < 4; n++)
               if ($urandom_range(1, 0) == 0) disp_num[4*n +: 4] = 4'h0;
         end
         if ($urandom_range(49, 0) == 0) disp_en = ~disp_en;
         if ($urandom_range(39, 0) == 0) lz_suppress = ~lz_suppress;
         if ($urandom_range(59, 0) == 0) blink_mask = 4'($urandom);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
